// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
// Frame is fixed at 8N1; the FSM encoding is plain 3-bit binary.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } rx_state_e;

    function automatic int cnt_width(input int clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// RST_VAL sets the value the chain holds in reset (the line's idle level).
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready byte interface.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    // The IDLE cycle that spots the falling edge already counts toward the half-bit wait.
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 byte_done_q, byte_done_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    uart_sync #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    state_d   = rx_s ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == IDX_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    if (rx_s) begin
                        byte_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BRK;
                    end
                end
            end
            BRK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // A completed byte is offered one cycle after the stop sample; a full, unaccepted holding register drops it.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (byte_done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 11 clocks/bit, plus byte sweeps at 4 and 16 clocks/bit.
module tb_uart_rx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic rx11 = 1'b1, rx4 = 1'b1, rx16 = 1'b1;
    logic rdy11 = 1'b0, rdy4 = 1'b1, rdy16 = 1'b1;
    logic [7:0] d11, d4, d16;
    logic v11, v4, v16, fe11, fe4, fe16, ov11, ov4, ov16, b11, b4, b16;

    uart_rx #(.CLKS_PER_BIT(11)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx11), .rx_data(d11), .rx_valid(v11),
        .rx_ready(rdy11), .frame_err(fe11), .overrun(ov11), .busy(b11)
    );
    uart_rx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rx(rx4), .rx_data(d4), .rx_valid(v4),
        .rx_ready(rdy4), .frame_err(fe4), .overrun(ov4), .busy(b4)
    );
    uart_rx #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .rx(rx16), .rx_data(d16), .rx_valid(v16),
        .rx_ready(rdy16), .frame_err(fe16), .overrun(ov16), .busy(b16)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ferr_cnt = 0, ovr_cnt = 0, vrise_cnt = 0, both_cnt = 0, sweep_flag_cnt = 0;
    logic vprev = 1'b0;
    logic [7:0] got4[$];
    logic [7:0] got16[$];
    logic [7:0] sent4[8];
    logic [7:0] sent16[8];

    always @(negedge clk) begin
        if (rst_n) begin
            if (fe11) ferr_cnt++;
            if (ov11) ovr_cnt++;
            if (fe11 && ov11) both_cnt++;
            if (v11 && !vprev) vrise_cnt++;
            if (fe4 || ov4 || fe16 || ov16) sweep_flag_cnt++;
            if (v4 && rdy4) got4.push_back(d4);
            if (v16 && rdy16) got16.push_back(d16);
        end
        vprev = v11;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx11 = v;
            1:       rx4  = v;
            default: rx16 = v;
        endcase
    endtask

    // rdy_at >= 0 pulses rdy11 for that one cycle of the frame; limit >= 0 abandons the frame early.
    task automatic send(input int sel, input int cpb, input logic [7:0] b, input logic stop_bit,
                        input int rdy_at, input int limit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10 * cpb; k++) begin
            if (limit >= 0 && k >= limit) return;
            set_rx(sel, frame[k / cpb]);
            if (rdy_at >= 0) rdy11 = (k == rdy_at);
            tick(1);
        end
    endtask

    task automatic accept11();
        rdy11 = 1'b1;
        tick(1);
        rdy11 = 1'b0;
    endtask

    initial begin
        int f0, o0, r0;

        #1;
        chk("rst_data", 32'(d11), 32'h0);
        chk("rst_valid", 32'(v11), 32'h0);
        chk("rst_busy", 32'(b11), 32'h0);
        chk("rst_ferr", 32'(fe11), 32'h0);
        chk("rst_ovr", 32'(ov11), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // 1: clean frame, held until accepted
        f0 = ferr_cnt; o0 = ovr_cnt;
        send(0, 11, 8'hA5, 1'b1, -1, -1);
        tick(3);
        chk("t1_valid", 32'(v11), 32'h1);
        chk("t1_data", 32'(d11), 32'hA5);
        tick(20);
        chk("t1_hold_valid", 32'(v11), 32'h1);
        chk("t1_hold_data", 32'(d11), 32'hA5);
        accept11();
        chk("t1_accept", 32'(v11), 32'h0);
        chk("t1_ferr", 32'(ferr_cnt - f0), 32'h0);
        chk("t1_ovr", 32'(ovr_cnt - o0), 32'h0);

        // 2: short low glitch is rejected
        f0 = ferr_cnt; o0 = ovr_cnt; r0 = vrise_cnt;
        set_rx(0, 1'b0);
        tick(3);
        set_rx(0, 1'b1);
        tick(1);
        chk("t2_busy_start", 32'(b11), 32'h1);
        tick(7);
        chk("t2_busy_idle", 32'(b11), 32'h0);
        chk("t2_valid", 32'(vrise_cnt - r0), 32'h0);
        chk("t2_ferr", 32'(ferr_cnt - f0), 32'h0);
        chk("t2_ovr", 32'(ovr_cnt - o0), 32'h0);

        // 3: bad stop bit followed by a held-low break, then a good frame
        f0 = ferr_cnt; r0 = vrise_cnt;
        send(0, 11, 8'h3C, 1'b0, -1, -1);
        tick(40);
        set_rx(0, 1'b1);
        tick(5);
        chk("t3_ferr_once", 32'(ferr_cnt - f0), 32'h1);
        chk("t3_no_valid", 32'(vrise_cnt - r0), 32'h0);
        chk("t3_busy", 32'(b11), 32'h0);
        send(0, 11, 8'h55, 1'b1, -1, -1);
        tick(3);
        chk("t3_valid", 32'(v11), 32'h1);
        chk("t3_data", 32'(d11), 32'h55);
        chk("t3_ferr_after", 32'(ferr_cnt - f0), 32'h1);
        accept11();

        // 4: back-to-back frames with nobody accepting
        o0 = ovr_cnt;
        send(0, 11, 8'h00, 1'b1, -1, -1);
        send(0, 11, 8'hFF, 1'b1, -1, -1);
        tick(3);
        chk("t4_ovr", 32'(ovr_cnt - o0), 32'h1);
        chk("t4_data", 32'(d11), 32'h00);
        chk("t4_valid", 32'(v11), 32'h1);
        accept11();

        // 5: accept lands exactly on the second delivery cycle
        o0 = ovr_cnt;
        send(0, 11, 8'h00, 1'b1, -1, -1);
        send(0, 11, 8'hFF, 1'b1, 106, -1);
        tick(3);
        chk("t5_ovr", 32'(ovr_cnt - o0), 32'h0);
        chk("t5_data", 32'(d11), 32'hFF);
        chk("t5_valid", 32'(v11), 32'h1);
        accept11();

        // 6: reset in the middle of a frame
        r0 = vrise_cnt;
        send(0, 11, 8'h81, 1'b1, -1, 50);
        chk("t6_busy_mid", 32'(b11), 32'h1);
        rst_n = 1'b0;
        set_rx(0, 1'b1);
        #1;
        chk("t6_rst_busy", 32'(b11), 32'h0);
        chk("t6_rst_valid", 32'(v11), 32'h0);
        chk("t6_rst_data", 32'(d11), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(15);
        send(0, 11, 8'h7E, 1'b1, -1, -1);
        tick(3);
        chk("t6_valid", 32'(v11), 32'h1);
        chk("t6_data", 32'(d11), 32'h7E);
        chk("t6_one_delivery", 32'(vrise_cnt - r0), 32'h1);
        accept11();

        // Sweeps at the minimum and a larger bit period
        for (int i = 0; i < 8; i++) begin
            sent4[i] = 8'($urandom);
            send(1, 4, sent4[i], 1'b1, -1, -1);
        end
        tick(20);
        chk("s4_count", 32'(got4.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got4.size()) chk($sformatf("s4_byte%0d", i), 32'(got4[i]), 32'(sent4[i]));
        end
        for (int i = 0; i < 8; i++) begin
            sent16[i] = 8'($urandom);
            send(2, 16, sent16[i], 1'b1, -1, -1);
        end
        tick(30);
        chk("s16_count", 32'(got16.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got16.size()) chk($sformatf("s16_byte%0d", i), 32'(got16[i]), 32'(sent16[i]));
        end
        chk("sweep_flags", 32'(sweep_flag_cnt), 32'h0);
        chk("sweep_busy", 32'({b4, b16}), 32'h0);
        chk("ferr_ovr_same_cycle", 32'(both_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
